// File: rtl/mips_decode_exec_mem.sv
// Execution slice of a five-stage MIPS pipeline: control decode, ALU with operand
// selection, and a big-endian byte-addressed data memory with combinational read.
module mips_decode_exec_mem #(
   parameter int DM_BYTES = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        mem_en,
   output logic        halt,
   output logic        regdst,
   output logic        regwre,
   output logic        dm_rd,
   output logic        dm_wr,
   output logic        dbdatasrc,
   output logic        dmdatasize,
   output logic        alusrcA,
   output logic        alusrcB,
   output logic        extsign,
   output logic [2:0]  aluctr,
   output logic        jump,
   output logic        branch_eq,
   output logic        branch_ne,
   output logic        branch_lt,
   output logic        link,
   output logic        jr,
   output logic [31:0] alu_res,
   output logic        zero,
   output logic        wrctr,
   output logic [31:0] mem_rdata
);
   localparam int AW = $clog2(DM_BYTES);

   logic [5:0]    opcode, funct;
   logic [4:0]    sa;
   logic [15:0]   imm;
   logic [31:0]   op_a, op_b;
   logic [AW-1:0] idx, wbase;
   logic [7:0]    mem_q [DM_BYTES];

   assign opcode = instr[31:26];
   assign sa     = instr[10:6];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];

   always_comb begin
      halt = 1'b0; regdst = 1'b0; regwre = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
      dbdatasrc = 1'b0; dmdatasize = 1'b0; alusrcA = 1'b0; alusrcB = 1'b0;
      extsign = 1'b0; aluctr = 3'b000; jump = 1'b0; branch_eq = 1'b0;
      branch_ne = 1'b0; branch_lt = 1'b0; link = 1'b0; jr = 1'b0;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h20: begin aluctr = 3'b000; regdst = 1'b1; regwre = 1'b1; end
               6'h22: begin aluctr = 3'b001; regdst = 1'b1; regwre = 1'b1; end
               6'h24: begin aluctr = 3'b010; regdst = 1'b1; regwre = 1'b1; end
               6'h25: begin aluctr = 3'b011; regdst = 1'b1; regwre = 1'b1; end
               6'h2A: begin aluctr = 3'b100; regdst = 1'b1; regwre = 1'b1; end
               6'h00: begin aluctr = 3'b101; regdst = 1'b1; regwre = 1'b1; alusrcA = 1'b1; end
               6'h0B: begin aluctr = 3'b110; regdst = 1'b1; regwre = 1'b1; end
               6'h08: jr = 1'b1;
               default: ;
            endcase
         end
         6'h08: begin aluctr = 3'b000; alusrcB = 1'b1; extsign = 1'b1; regwre = 1'b1; end
         6'h0C: begin aluctr = 3'b010; alusrcB = 1'b1; regwre = 1'b1; end
         6'h0D: begin aluctr = 3'b011; alusrcB = 1'b1; regwre = 1'b1; end
         6'h0A: begin aluctr = 3'b100; alusrcB = 1'b1; extsign = 1'b1; regwre = 1'b1; end
         6'h23, 6'h20: begin
            alusrcB = 1'b1; extsign = 1'b1; regwre = 1'b1; dm_rd = 1'b1; dbdatasrc = 1'b1;
            dmdatasize = (opcode == 6'h20);
         end
         6'h2B, 6'h28: begin
            alusrcB = 1'b1; extsign = 1'b1; dm_wr = 1'b1;
            dmdatasize = (opcode == 6'h28);
         end
         6'h04: begin aluctr = 3'b001; branch_eq = 1'b1; end
         6'h05: begin aluctr = 3'b001; branch_ne = 1'b1; end
         6'h01: begin aluctr = 3'b001; branch_lt = 1'b1; end
         6'h02: jump = 1'b1;
         6'h03: begin link = 1'b1; regwre = 1'b1; end
         6'h3F: halt = 1'b1;
         default: ;
      endcase
   end

   assign op_a = alusrcA ? {27'b0, sa} : rs_data;
   assign op_b = alusrcB ? (extsign ? {{16{imm[15]}}, imm} : {16'b0, imm}) : rt_data;

   always_comb begin
      alu_res = '0;
      wrctr   = 1'b1;
      case (aluctr)
         3'b000: begin
            alu_res = op_a + op_b;
            wrctr   = !((op_a[31] == op_b[31]) && (alu_res[31] != op_a[31]));
         end
         3'b001: begin
            alu_res = op_a - op_b;
            wrctr   = !((op_a[31] != op_b[31]) && (alu_res[31] != op_a[31]));
         end
         3'b010: alu_res = op_a & op_b;
         3'b011: alu_res = op_a | op_b;
         3'b100: alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
         3'b101: alu_res = op_b << op_a[4:0];
         3'b110: begin
            alu_res = op_a;
            wrctr   = (op_b != 32'b0);   // movn commits only when rt is non-zero
         end
         default: alu_res = op_a ^ op_b;
      endcase
   end

   assign zero = (alu_res == 32'b0);

   // Word accesses ignore the two low address bits; memory wraps modulo DM_BYTES.
   assign idx   = alu_res[AW-1:0];
   assign wbase = {idx[AW-1:2], 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DM_BYTES; i++) mem_q[i] <= 8'h00;
      end else if (dm_wr && mem_en) begin
         if (dmdatasize) begin
            mem_q[idx] <= rt_data[7:0];
         end else begin
            mem_q[wbase]         <= rt_data[31:24];
            mem_q[wbase + AW'(1)] <= rt_data[23:16];
            mem_q[wbase + AW'(2)] <= rt_data[15:8];
            mem_q[wbase + AW'(3)] <= rt_data[7:0];
         end
      end
   end

   always_comb begin
      mem_rdata = '0;
      if (dm_rd) begin
         if (dmdatasize)
            mem_rdata = {{24{mem_q[idx][7]}}, mem_q[idx]};
         else
            mem_rdata = {mem_q[wbase], mem_q[wbase + AW'(1)],
                         mem_q[wbase + AW'(2)], mem_q[wbase + AW'(3)]};
      end
   end
endmodule

// File: tb/tb_mips_decode_exec_mem.sv
// Directed-vector bench for the decode/ALU/data-memory slice.
module tb_mips_decode_exec_mem;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr, rs_data, rt_data;
   logic        mem_en;
   logic        halt, regdst, regwre, dm_rd, dm_wr, dbdatasrc, dmdatasize;
   logic        alusrcA, alusrcB, extsign, jump, branch_eq, branch_ne, branch_lt, link, jr;
   logic [2:0]  aluctr;
   logic [31:0] alu_res, mem_rdata;
   logic        zero, wrctr;

   int n_tests = 0;
   int n_fail  = 0;

   // control-vector bit masks
   localparam logic [15:0] H  = 16'h8000, RD = 16'h4000, RW = 16'h2000, DR = 16'h1000;
   localparam logic [15:0] DW = 16'h0800, DS = 16'h0400, SZ = 16'h0200, SA = 16'h0100;
   localparam logic [15:0] SB = 16'h0080, EX = 16'h0040, J  = 16'h0020, BE = 16'h0010;
   localparam logic [15:0] BN = 16'h0008, BL = 16'h0004, LK = 16'h0002, JR = 16'h0001;

   logic [15:0] ctl;
   assign ctl = {halt, regdst, regwre, dm_rd, dm_wr, dbdatasrc, dmdatasize, alusrcA,
                 alusrcB, extsign, jump, branch_eq, branch_ne, branch_lt, link, jr};

   mips_decode_exec_mem #(.DM_BYTES(128)) dut (
      .clk(clk), .reset(reset), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
      .mem_en(mem_en), .halt(halt), .regdst(regdst), .regwre(regwre), .dm_rd(dm_rd),
      .dm_wr(dm_wr), .dbdatasrc(dbdatasrc), .dmdatasize(dmdatasize), .alusrcA(alusrcA),
      .alusrcB(alusrcB), .extsign(extsign), .aluctr(aluctr), .jump(jump),
      .branch_eq(branch_eq), .branch_ne(branch_ne), .branch_lt(branch_lt), .link(link),
      .jr(jr), .alu_res(alu_res), .zero(zero), .wrctr(wrctr), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: 0x%08h", tag, obs);
      end
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      instr = i; rs_data = a; rt_data = b;
      #1;
   endtask

   // store: drive between edges, take one rising edge, settle
   task automatic store(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                        input logic en);
      @(negedge clk);
      mem_en = en;
      drive(i, a, b);
      @(posedge clk);
      #1;
      mem_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; mem_en = 1'b0;
      drive(32'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset-state: all-zero instruction is sll $0,$0,0 -> result 0
      drive(32'h0000_0000, 32'h0, 32'h0);
      check_eq("sll0_res", alu_res, 32'h0);
      check_eq("sll0_zero", {31'b0, zero}, 32'h1);

      drive(32'h0022_1820, 32'd5, 32'd7);
      check_eq("add_res", alu_res, 32'd12);
      check_eq("add_ctl", {13'b0, aluctr, ctl}, {16'h0, RD | RW});
      check_eq("add_wrctr", {31'b0, wrctr}, 32'h1);

      drive(32'h0022_1820, 32'h7FFF_FFFF, 32'd1);
      check_eq("addov_res", alu_res, 32'h8000_0000);
      check_eq("addov_wrctr", {31'b0, wrctr}, 32'h0);

      drive(32'h0022_1822, 32'd9, 32'd9);
      check_eq("sub_zero", {31'b0, zero}, 32'h1);
      check_eq("sub_aluctr", {29'b0, aluctr}, 32'h1);
      drive(32'h0022_1822, 32'h8000_0000, 32'd1);
      check_eq("subov_wrctr", {31'b0, wrctr}, 32'h0);

      drive(32'h0022_1824, 32'h0000_F0F0, 32'h0000_FF00);
      check_eq("and_res", alu_res, 32'h0000_F000);
      drive(32'h0022_1825, 32'h0000_F0F0, 32'h0000_FF00);
      check_eq("or_res", alu_res, 32'h0000_FFF0);
      drive(32'h0022_182A, 32'hFFFF_FFFF, 32'd1);
      check_eq("slt_res", alu_res, 32'd1);
      drive(32'h0022_182A, 32'd1, 32'hFFFF_FFFF);
      check_eq("slt_res0", alu_res, 32'd0);

      drive(32'h0002_1900, 32'h0000_FFFF, 32'd3);   // sll rd, rt, 4
      check_eq("sll_res", alu_res, 32'h30);
      check_eq("sll_ctl", {16'b0, ctl}, {16'b0, RD | RW | SA});

      drive(32'h0022_180B, 32'h1234, 32'd0);
      check_eq("movn_res", alu_res, 32'h1234);
      check_eq("movn_wr0", {31'b0, wrctr}, 32'h0);
      drive(32'h0022_180B, 32'h1234, 32'd5);
      check_eq("movn_wr1", {31'b0, wrctr}, 32'h1);

      drive(32'h3022_8001, 32'hFFFF_FFFF, 32'h0);   // andi
      check_eq("andi_res", alu_res, 32'h0000_8001);
      drive(32'h3422_8000, 32'd1, 32'h0);           // ori
      check_eq("ori_res", alu_res, 32'h0000_8001);
      drive(32'h2022_FFFF, 32'd5, 32'h0);           // addi -1
      check_eq("addi_res", alu_res, 32'd4);
      drive(32'h2822_FFFF, 32'hFFFF_FFFE, 32'h0);   // slti -2 < -1
      check_eq("slti_res", alu_res, 32'd1);

      drive(32'h1022_0003, 32'd1, 32'd2);
      check_eq("beq_ctl", {13'b0, aluctr, ctl}, {16'h1, BE});
      drive(32'h1422_0003, 32'd1, 32'd2);
      check_eq("bne_ctl", {13'b0, aluctr, ctl}, {16'h1, BN});
      drive(32'h0420_0005, 32'd1, 32'd0);
      check_eq("bltz_ctl", {13'b0, aluctr, ctl}, {16'h1, BL});
      drive(32'h0800_0010, 32'd0, 32'd0);
      check_eq("j_ctl", {16'b0, ctl}, {16'b0, J});
      drive(32'h0C00_0010, 32'd0, 32'd0);
      check_eq("jal_ctl", {16'b0, ctl}, {16'b0, LK | RW});
      drive(32'hFC00_0000, 32'd0, 32'd0);
      check_eq("halt_ctl", {16'b0, ctl}, {16'b0, H});
      drive(32'h03E0_0008, 32'd0, 32'd0);
      check_eq("jr_ctl", {16'b0, ctl}, {16'b0, JR});
      drive(32'hF800_0000, 32'd0, 32'd0);
      check_eq("nop_op", {13'b0, aluctr, ctl}, 32'h0);
      drive(32'h0022_183F, 32'd0, 32'd0);
      check_eq("nop_fn", {13'b0, aluctr, ctl}, 32'h0);

      // memory: sw then lw
      store(32'hAC02_0004, 32'h10, 32'hDEAD_BEEF, 1'b1);
      check_eq("sw_ctl", {16'b0, ctl}, {16'b0, SB | EX | DW});
      check_eq("sw_rdata0", mem_rdata, 32'h0);
      drive(32'h8C02_0004, 32'h10, 32'h0);
      check_eq("lw_ctl", {16'b0, ctl}, {16'b0, SB | EX | RW | DR | DS});
      check_eq("lw_rdata", mem_rdata, 32'hDEAD_BEEF);
      drive(32'h8C02_0017, 32'h0, 32'h0);           // unaligned 0x17 -> word 0x14
      check_eq("lw_unal", mem_rdata, 32'hDEAD_BEEF);
      drive(32'h8C02_0094, 32'h0, 32'h0);           // 0x94 wraps to 0x14
      check_eq("lw_wrap", mem_rdata, 32'hDEAD_BEEF);
      drive(32'h8002_0015, 32'h0, 32'h0);           // lb 0x15 -> 0xAD
      check_eq("lb_ad", mem_rdata, 32'hFFFF_FFAD);

      // sb then lb/lw
      store(32'hA002_0021, 32'h0, 32'h0000_0080, 1'b1);
      drive(32'h8002_0021, 32'h0, 32'h0);
      check_eq("lb_ctl", {16'b0, ctl}, {16'b0, SB | EX | RW | DR | DS | SZ});
      check_eq("lb_rdata", mem_rdata, 32'hFFFF_FF80);
      drive(32'h8C02_0020, 32'h0, 32'h0);
      check_eq("lw_after_sb", mem_rdata, 32'h0080_0000);

      // mid-run reset clears memory asynchronously
      @(negedge clk);
      reset = 1'b1;
      #2;
      drive(32'h8C02_0020, 32'h0, 32'h0);
      check_eq("lw_in_reset", mem_rdata, 32'h0);
      reset = 1'b0;
      drive(32'h8C02_0020, 32'h0, 32'h0);
      check_eq("lw_after_rst", mem_rdata, 32'h0);
      drive(32'h8C02_0004, 32'h10, 32'h0);
      check_eq("lw14_after_rst", mem_rdata, 32'h0);

      // store with mem_en=0 is a bubble
      store(32'hAC02_0020, 32'h0, 32'h1234_5678, 1'b0);
      drive(32'h8C02_0020, 32'h0, 32'h0);
      check_eq("bubble_sw", mem_rdata, 32'h0);
      store(32'hAC02_0020, 32'h0, 32'h1234_5678, 1'b1);
      drive(32'h8C02_0020, 32'h0, 32'h0);
      check_eq("sw_en", mem_rdata, 32'h1234_5678);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
